gcd_feeder: RTL and testbench
=============================

# gcd_feeder

Upstream job queue and handshake driver for the `gcd_calc` stage. It accepts operand pairs from a valid/ready producer and buffers them in a DEPTH-entry FIFO. It issues them one at a time to the calculator using the calculator's level start/done protocol, and returns each result with a one-cycle valid strobe. Pairs with a zero operand never reach the calculator, because it does not terminate on zero; the feeder resolves them locally.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries. Power of two, at least 2.
- `W`, default 8: operand and result width. Must match the calculator.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `in_valid`, input, 1: producer offers a pair.
- `in_p`, input, W: operand P.
- `in_q`, input, W: operand Q.
- `in_ready`, output, 1: FIFO can accept. Equals `!full`.
- `calc_start`, output, 1: start level to the calculator.
- `calc_p`, output, W: registered operand P to the calculator.
- `calc_q`, output, W: registered operand Q to the calculator.
- `calc_r`, input, W: calculator result.
- `calc_done`, input, 1: calculator done level.
- `res_valid`, output, 1: one-cycle strobe; `res_r` is valid this cycle.
- `res_r`, output, W: GCD result, held until the next strobe.
- `busy`, output, 1: high when the FIFO is non-empty or the state is not IDLE.

## Operation
- Push: on a rising edge with `in_valid && in_ready`, write {`in_p`, `in_q`} at the tail. No push is possible when full. The producer holds its data until accepted.
- Pop occurs only in IDLE, when the FIFO is non-empty. A push and a pop in the same cycle are both performed; the count is unchanged.
- States:
  - IDLE: FIFO empty, stay.
    - Head has a zero operand (`p==0 || q==0`): pop. Set `res_r <= p | q` and `res_valid <= 1`. Stay in IDLE. So gcd(0,x)=x and gcd(0,0)=0.
    - Otherwise: pop. Load `calc_p`/`calc_q` from the head. Set `calc_start <= 1`. Go to BUSY.
  - BUSY: hold `calc_start=1`, with `calc_p`/`calc_q` stable.
    - On `calc_done==1`: `res_r <= calc_r`, `res_valid <= 1`, `calc_start <= 0`, go to DRAIN.
  - DRAIN: hold `calc_start=0`.
    - On `calc_done==0`: go to IDLE.
    - This step is required. Without it, the feeder would re-start the calculator before it has returned to its idle state.
- `res_valid` is high for exactly one cycle per accepted pair. Results appear in push order.
- Reset values: `calc_start=0`, `calc_p=0`, `calc_q=0`, `res_valid=0`, `res_r=0`, FIFO empty, `in_ready=1`, `busy=0`, state IDLE.
- Reset mid-operation, in any state: all queued pairs are discarded and no `res_valid` is produced for them. The calculator shares `rst`, so both blocks restart clean.
- `calc_done` arriving in IDLE or DRAIN without a matching start is ignored.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. Full = MSBs differ and LSBs are equal. Empty = pointers are equal.

## Timing
- A pair pushed at edge t is visible at the head from t+1. If the FIFO was empty and the state is IDLE, `calc_start` rises at edge t+1.
- A zero-operand pair pushed at edge t produces `res_valid` from edge t+1 to t+2.
- For a calculator pair: `res_valid` rises at the first edge where `calc_done` is sampled high. `calc_start` falls at the same edge.
- The minimum gap between consecutive `calc_start` assertions is DRAIN duration + 1 cycle.
- `in_ready` is combinational from the pointers. It falls in the cycle after the push that fills the FIFO, and rises in the cycle after the pop from full.
- All outputs except `in_ready` are registered.

## Test plan
- Basic GCD: push (24,18) into an idle feeder connected to `gcd_calc` -> `calc_start` rises the next cycle; `res_valid` pulses once with `res_r=6`; `calc_start` is low before `calc_done` drops; the feeder returns to IDLE.
- Equal operands and order: push (7,7), then (48,36), then (13,5) back-to-back -> three `res_valid` pulses, in order, with `res_r` = 7, 12, 1.
- Zero bypass: push (0,15), then (20,0), then (0,0) -> `calc_start` never asserts; `res_valid` pulses with `res_r` = 15, 20, 0; each pulse is one cycle after its pop.
- Full and backpressure: with `calc_done` tied low, hold `in_valid` and push 6 pairs -> the first pair enters BUSY; 4 more pairs are accepted; `in_ready=0` on the sixth and that pair is held. Release `calc_done` -> the sixth pair is accepted after the next pop.
- Simultaneous push and pop: FIFO at count 2 and IDLE, push on the same edge as a pop -> count stays 2 and no data is lost or duplicated.
- Reset mid-job: assert `rst` low while in BUSY with 3 pairs queued -> `calc_start=0`, `res_valid=0`, `in_ready=1`, `busy=0` immediately. After release, push (9,6) -> `res_r=3`.

Source files
------------

// File: rtl/gcd_feeder.sv
// gcd_feeder: job queue in front of the gcd_calc stage.
// Operand pairs from a valid/ready producer are buffered in a DEPTH-entry
// FIFO. Each pair is then either resolved locally (a zero operand, which
// the calculator cannot terminate on) or handed to the calculator over its
// level start/done handshake. Every accepted pair yields exactly one
// res_valid strobe, and results come out in push order.
module gcd_feeder #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_p,
    input  logic [W-1:0] in_q,
    output logic         in_ready,
    output logic         calc_start,
    output logic [W-1:0] calc_p,
    output logic [W-1:0] calc_q,
    input  logic [W-1:0] calc_r,
    input  logic         calc_done,
    output logic         res_valid,
    output logic [W-1:0] res_r,
    output logic         busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // FIFO storage and pointers. The pointers carry one extra wrap bit, so
    // full and empty can be told apart without a separate counter.
    logic [W-1:0] r_mem_p [DEPTH];
    logic [W-1:0] r_mem_q [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;

    state_t       r_state;
    logic         r_calc_start;
    logic [W-1:0] r_calc_p;
    logic [W-1:0] r_calc_q;
    logic         r_res_valid;
    logic [W-1:0] r_res_r;
    logic         r_busy;

    logic         w_full;
    logic         w_empty;
    logic         w_push;
    logic         w_pop;
    logic [W-1:0] w_head_p;
    logic [W-1:0] w_head_q;
    logic         w_head_zero;
    logic [AW:0]  w_wptr_nxt;
    logic [AW:0]  w_rptr_nxt;
    state_t       w_state_nxt;
    logic         w_calc_load;
    logic         w_calc_start_nxt;
    logic         w_res_valid_nxt;
    logic [W-1:0] w_res_r_nxt;
    logic         w_busy_nxt;

    // FIFO status and head decode; in_ready is the only combinational output.
    assign w_empty     = (r_wptr == r_rptr);
    assign w_full      = (r_wptr[AW] != r_rptr[AW]) &&
                         (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push      = in_valid && !w_full;
    assign w_head_p    = r_mem_p[r_rptr[AW-1:0]];
    assign w_head_q    = r_mem_q[r_rptr[AW-1:0]];
    assign w_head_zero = (w_head_p == '0) || (w_head_q == '0);
    assign w_wptr_nxt  = w_push ? (r_wptr + PTR_ONE) : r_wptr;
    assign w_rptr_nxt  = w_pop  ? (r_rptr + PTR_ONE) : r_rptr;

    // busy is registered, so it is computed from the next FIFO and FSM state.
    assign w_busy_nxt  = (w_wptr_nxt != w_rptr_nxt) || (w_state_nxt != S_IDLE);

    // Payload storage: a write happens only on an accepted push. The queued
    // data needs no reset, because the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_p[r_wptr[AW-1:0]] <= in_p;
            r_mem_q[r_wptr[AW-1:0]] <= in_q;
        end
    end

    // Pointer registers. A reset empties the queue, which drops every
    // pending pair.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            r_wptr <= w_wptr_nxt;
            r_rptr <= w_rptr_nxt;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. DRAIN waits for the calculator to drop done, so it
    // is back in its idle state before the next start is issued.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !w_head_zero) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (calc_done) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!calc_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output and pop decode. A head with a zero operand is resolved in place
    // as p|q, which gives gcd(0,x)=x and gcd(0,0)=0. Any done seen outside
    // BUSY is stray and is ignored.
    always_comb begin
        w_pop            = 1'b0;
        w_calc_load      = 1'b0;
        w_calc_start_nxt = 1'b0;
        w_res_valid_nxt  = 1'b0;
        w_res_r_nxt      = r_res_r;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head_zero) begin
                        w_res_valid_nxt = 1'b1;
                        w_res_r_nxt     = w_head_p | w_head_q;
                    end else begin
                        w_calc_load      = 1'b1;
                        w_calc_start_nxt = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                if (calc_done) begin
                    w_res_valid_nxt = 1'b1;
                    w_res_r_nxt     = calc_r;
                end else begin
                    w_calc_start_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs. calc_p/calc_q change only when a new job is
    // loaded, so they stay stable for the whole time start is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_calc_start <= 1'b0;
            r_calc_p     <= '0;
            r_calc_q     <= '0;
            r_res_valid  <= 1'b0;
            r_res_r      <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_calc_start <= w_calc_start_nxt;
            r_res_valid  <= w_res_valid_nxt;
            r_res_r      <= w_res_r_nxt;
            r_busy       <= w_busy_nxt;
            if (w_calc_load) begin
                r_calc_p <= w_head_p;
                r_calc_q <= w_head_q;
            end
        end
    end

    assign in_ready   = !w_full;
    assign calc_start = r_calc_start;
    assign calc_p     = r_calc_p;
    assign calc_q     = r_calc_q;
    assign res_valid  = r_res_valid;
    assign res_r      = r_res_r;
    assign busy       = r_busy;

endmodule

// File: tb/tb_gcd_feeder.sv
// Directed bench for gcd_feeder. A small behavioural calculator answers
// start with done after a few cycles. It can be stalled (hold_low) or made
// to raise a stray done (spur). Results are captured in a queue and
// compared against hand-computed GCDs.
`timescale 1ns/1ps
module tb_gcd_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_p, in_q;
    logic       in_ready;
    logic       calc_start;
    logic [7:0] calc_p, calc_q;
    logic [7:0] calc_r;
    logic       calc_done;
    logic       res_valid;
    logic [7:0] res_r;
    logic       busy;

    logic       m_done;
    logic [1:0] m_cnt;
    logic       hold_low, spur;

    int         checks = 0;
    int         failures = 0;
    int         start_cnt = 0;
    logic       start_prev = 1'b0;
    logic [7:0] resq[$];

    always #5 clk = ~clk;

    gcd_feeder #(.DEPTH(4), .W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_p(in_p), .in_q(in_q),
        .in_ready(in_ready), .calc_start(calc_start), .calc_p(calc_p),
        .calc_q(calc_q), .calc_r(calc_r), .calc_done(calc_done),
        .res_valid(res_valid), .res_r(res_r), .busy(busy)
    );

    function automatic logic [7:0] gcd8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Calculator model: done rises three cycles after start is seen, and
    // falls once start is dropped.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_done <= 1'b0;
            m_cnt  <= 2'd0;
            calc_r <= 8'd0;
        end else if (!calc_start) begin
            m_done <= 1'b0;
            m_cnt  <= 2'd0;
        end else if (!m_done && !hold_low) begin
            if (m_cnt == 2'd2) begin
                m_done <= 1'b1;
                calc_r <= gcd8(calc_p, calc_q);
            end else begin
                m_cnt <= m_cnt + 2'd1;
            end
        end
    end
    assign calc_done = m_done | spur;

    // Monitor: capture results and count calc_start rising edges.
    always @(negedge clk) begin
        if (res_valid) resq.push_back(res_r);
        if (calc_start && !start_prev) start_cnt++;
        start_prev = calc_start;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Offer a pair from a negedge and wait up to lim edges for acceptance.
    // If the pair is not accepted, in_valid is left high so it stays held.
    task automatic push_try(input logic [7:0] p, input logic [7:0] q, input int lim,
                            output bit acc);
        logic a;
        in_valid = 1'b1;
        in_p = p;
        in_q = q;
        acc = 1'b0;
        for (int i = 0; i < lim; i++) begin
            a = in_ready;
            @(posedge clk);
            @(negedge clk);
            if (a) begin
                acc = 1'b1;
                break;
            end
        end
        if (acc) in_valid = 1'b0;
    endtask

    task automatic wait_res(input string tag, input int n, input int lim);
        for (int i = 0; i < lim; i++) begin
            if (resq.size() >= n) break;
            @(negedge clk);
        end
        chk(tag, resq.size(), n);
    endtask

    task automatic wait_pulse(input string tag, input int lim);
        bit got;
        got = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (res_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk(tag, got, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit acc;
        int s0;
        logic [7:0] fp[6];
        logic [7:0] fq[6];
        logic [7:0] fr[6];
        fp = '{8'd12, 8'd9, 8'd10, 8'd14, 8'd25, 8'd27};
        fq = '{8'd8,  8'd3, 8'd4,  8'd21, 8'd15, 8'd18};
        fr = '{8'd4,  8'd3, 8'd2,  8'd7,  8'd5,  8'd9};

        rst = 1'b0; in_valid = 1'b0; in_p = '0; in_q = '0;
        hold_low = 1'b0; spur = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_start", calc_start, 0);
        chk("rst_p", calc_p, 0);
        chk("rst_q", calc_q, 0);
        chk("rst_rv", res_valid, 0);
        chk("rst_r", res_r, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        @(negedge clk);

        // Basic GCD, with start/done timing
        push_try(8'd24, 8'd18, 5, acc);
        chk("basic_acc", acc, 1);
        chk("basic_start_early", calc_start, 0);
        @(negedge clk);
        chk("basic_start", calc_start, 1);
        chk("basic_p", calc_p, 24);
        chk("basic_q", calc_q, 18);
        chk("basic_busy", busy, 1);
        wait_pulse("basic_pulse", 50);
        chk("basic_r", res_r, 6);
        chk("basic_start_low", calc_start, 0);
        chk("basic_done_still", calc_done, 1);
        @(negedge clk);
        chk("basic_one_cycle", res_valid, 0);
        repeat (4) @(negedge clk);
        chk("basic_idle", busy, 0);
        chk("basic_count", resq.size(), 1);
        resq.delete();

        // Equal operands and ordering
        push_try(8'd7, 8'd7, 5, acc);   chk("ord_acc0", acc, 1);
        push_try(8'd48, 8'd36, 5, acc); chk("ord_acc1", acc, 1);
        push_try(8'd13, 8'd5, 5, acc);  chk("ord_acc2", acc, 1);
        wait_res("ord_n", 3, 300);
        if (resq.size() == 3) begin
            chk("ord_r0", resq[0], 7);
            chk("ord_r1", resq[1], 12);
            chk("ord_r2", resq[2], 1);
        end
        repeat (6) @(negedge clk);
        chk("ord_idle", busy, 0);
        resq.delete();

        // Zero bypass: result one cycle after the pop, calculator untouched
        s0 = start_cnt;
        push_try(8'd0, 8'd15, 5, acc);
        @(negedge clk);
        chk("zero_rv0", res_valid, 1); chk("zero_r0", res_r, 15);
        push_try(8'd20, 8'd0, 5, acc);
        @(negedge clk);
        chk("zero_rv1", res_valid, 1); chk("zero_r1", res_r, 20);
        push_try(8'd0, 8'd0, 5, acc);
        @(negedge clk);
        chk("zero_rv2", res_valid, 1); chk("zero_r2", res_r, 0);
        @(negedge clk);
        chk("zero_nostart", start_cnt, s0);
        chk("zero_n", resq.size(), 3);
        resq.delete();

        // Stray done in IDLE is ignored
        spur = 1'b1;
        repeat (3) @(negedge clk);
        chk("spur_start", calc_start, 0);
        chk("spur_busy", busy, 0);
        spur = 1'b0;
        repeat (2) @(negedge clk);
        chk("spur_nores", resq.size(), 0);

        // Full and backpressure
        hold_low = 1'b1;
        for (int k = 0; k < 5; k++) begin
            push_try(fp[k], fq[k], 1, acc);
            chk("full_acc", acc, 1);
        end
        push_try(fp[5], fq[5], 3, acc);
        chk("full_block", acc, 0);
        chk("full_ready", in_ready, 0);
        chk("full_start", calc_start, 1);
        chk("full_p", calc_p, 12);
        hold_low = 1'b0;
        push_try(fp[5], fq[5], 60, acc);
        chk("full_late_acc", acc, 1);
        wait_res("full_n", 6, 500);
        if (resq.size() == 6)
            for (int k = 0; k < 6; k++) chk("full_r", resq[k], fr[k]);
        repeat (6) @(negedge clk);
        resq.delete();

        // Simultaneous push and pop at count 2
        hold_low = 1'b1;
        push_try(8'd6, 8'd4, 1, acc);   chk("sim_accA", acc, 1);
        push_try(8'd15, 8'd10, 1, acc); chk("sim_accB", acc, 1);
        push_try(8'd8, 8'd12, 1, acc);  chk("sim_accC", acc, 1);
        hold_low = 1'b0;
        wait_pulse("sim_pulseA", 50);
        hold_low = 1'b1;
        @(negedge clk);
        @(negedge clk);
        push_try(8'd21, 8'd14, 1, acc);  chk("sim_accD", acc, 1);
        chk("sim_popB_start", calc_start, 1);
        chk("sim_popB_p", calc_p, 15);
        push_try(8'd0, 8'd9, 1, acc);    chk("sim_accE", acc, 1);
        chk("sim_ready3", in_ready, 1);
        push_try(8'd35, 8'd49, 1, acc);  chk("sim_accF", acc, 1);
        chk("sim_ready4", in_ready, 0);
        hold_low = 1'b0;
        wait_res("sim_n", 6, 500);
        if (resq.size() == 6) begin
            chk("sim_r0", resq[0], 2);
            chk("sim_r1", resq[1], 5);
            chk("sim_r2", resq[2], 4);
            chk("sim_r3", resq[3], 7);
            chk("sim_r4", resq[4], 9);
            chk("sim_r5", resq[5], 7);
        end
        repeat (6) @(negedge clk);
        chk("sim_extra", resq.size(), 6);
        resq.delete();

        // Reset mid-job with 3 pairs queued
        hold_low = 1'b1;
        push_try(8'd30, 8'd12, 1, acc);
        push_try(8'd40, 8'd16, 1, acc);
        push_try(8'd0, 8'd5, 1, acc);
        push_try(8'd18, 8'd27, 1, acc);
        chk("mid_busy", calc_start, 1);
        rst = 1'b0;
        #1;
        chk("mid_start", calc_start, 0);
        chk("mid_rv", res_valid, 0);
        chk("mid_ready", in_ready, 1);
        chk("mid_busyo", busy, 0);
        hold_low = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        chk("mid_noresult", resq.size(), 0);
        chk("mid_idle", busy, 0);
        push_try(8'd9, 8'd6, 5, acc);
        wait_res("mid_n", 1, 100);
        if (resq.size() == 1) chk("mid_r", resq[0], 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
